condicionador_jogada: RTL
=========================

Name: condicionador_jogada

Overview:
Input conditioning stage sitting directly upstream of the memory-game circuit. It takes the raw `chaves[3:0]` switches and the raw `iniciar` button. For the switches it filters bounce, waits for a stable non-zero pattern, and registers it once. It then emits a single-cycle pulse marking the play as valid (one-hot) or invalid (multi-bit), and converts `iniciar` into a single-cycle pulse. Downstream control and datapath consume `chaves_estaveis` and the pulses instead of the raw inputs.

Parameters:
- DEBOUNCE_CICLOS, 4: number of consecutive identical samples required to accept a press and, separately, a release. Legal range 2..255.
- CONT_W, 8: width of the debounce counter. Must satisfy 2^CONT_W > DEBOUNCE_CICLOS.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- chaves  input  4  raw switch/button pattern.
- iniciar  input  1  raw start button.
- chaves_estaveis  output  4  last registered play; held until the next registration.
- jogada_valida  output  1  one-cycle pulse: registered play is one-hot.
- jogada_invalida  output  1  one-cycle pulse: registered play has more than one bit set.
- iniciar_pulso  output  1  one-cycle pulse on a rising edge of `iniciar`.
- db_estado  output  4  current FSM state code, for the hex display.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - FSM goes to OCIOSO; counter 0; internal sample register 0.
  - `chaves_estaveis` = 0; `jogada_valida` = 0; `jogada_invalida` = 0; `iniciar_pulso` = 0; `db_estado` = 0.
  - The `iniciar` previous-sample register is loaded with 1, so a button held through reset produces no pulse.
- State codes (`db_estado`): OCIOSO = 0, FILTRANDO = 1, REGISTRA = 2, ESPERA_SOLTAR = 3. Codes 4..15 are unused and decode to OCIOSO.
- OCIOSO:
  - chaves == 0: stay.
  - chaves != 0: amostra <= chaves, cnt <= 1, go to FILTRANDO.
- FILTRANDO (precedence: first row wins):
  - chaves == 0: cnt <= 0, go to OCIOSO.
  - chaves != amostra: amostra <= chaves, cnt <= 1, stay (count restarts).
  - chaves == amostra and cnt == DEBOUNCE_CICLOS-1: chaves_estaveis <= amostra, go to REGISTRA.
  - otherwise: cnt <= cnt + 1.
- REGISTRA (exactly one cycle; Moore outputs):
  - jogada_valida = 1 if chaves_estaveis is one-hot; else jogada_invalida = 1. Never both.
  - Unconditionally cnt <= 0, go to ESPERA_SOLTAR.
- ESPERA_SOLTAR:
  - chaves != 0: cnt <= 0.
  - chaves == 0 and cnt == DEBOUNCE_CICLOS-1: cnt <= 0, go to OCIOSO.
  - chaves == 0 otherwise: cnt <= cnt + 1.
  - Changes in `chaves` while waiting never produce a new registration.
- Press latency: pattern first sampled at edge k and held → REGISTRA entered at edge k+DEBOUNCE_CICLOS-1; pulse high for exactly the following cycle.
- Release latency: DEBOUNCE_CICLOS consecutive zero samples are required before a new press can be accepted.
- iniciar path:
  - iniciar_ant <= iniciar every cycle.
  - iniciar_pulso registered: <= iniciar & ~iniciar_ant. It is high for one cycle after the first sampled high.
  - Independent of the FSM, including during REGISTRA.
- Reset mid-operation: the FSM aborts immediately to OCIOSO, any pending pulse is suppressed, and `chaves_estaveis` clears to 0.
- The counter never wraps; it is bounded by DEBOUNCE_CICLOS-1 in all states.

Optional Feature:
- Macro: CONDICIONADOR_SINCRONIZADOR_EN.
- Defined: `chaves` and `iniciar` each pass through a 2-flop synchroniser before all logic described above. Synchroniser flops reset to 0, except the `iniciar` chain, which resets to 1. Every latency above increases by exactly 2 cycles.
- Undefined: raw inputs feed the logic directly; no extra flops are present.

Test Plan:
- Reset then chaves=0001 held (DEBOUNCE_CICLOS=4, first sampled at edge k) → db_estado=1 from k, =2 after k+3; jogada_valida=1 for exactly one cycle; chaves_estaveis=0001; jogada_invalida stays 0.
- chaves=0110 held 4 samples → jogada_invalida one-cycle pulse; chaves_estaveis=0110; jogada_valida stays 0.
- Bounce: 0010, 0000, 0010, 0100, then 0100 held → no pulse until 4 consecutive 0100 samples; a single jogada_valida pulse with chaves_estaveis=0100.
- After a registration, hold 1000 for 20 cycles, then pulse zeros for 2 cycles and 1000 again → no second pulse; 4 consecutive zeros are needed before OCIOSO; a later 1000 press registers normally.
- `iniciar` held high across reset release → no iniciar_pulso. Release, then raise → exactly one 1-cycle pulse; holding it 10 cycles gives no extra pulse.
- Assert reset for one cycle while in FILTRANDO with cnt=2 → next cycle db_estado=0 and all outputs 0. Repeat with CONDICIONADOR_SINCRONIZADOR_EN defined and check every latency is +2 cycles.

Source files
------------

// File: rtl/condicionador_jogada.sv
// Input conditioning for the memory game: debounces the switches, registers one stable play and
// pulses it as valid or invalid, and turns the start button into a single-cycle pulse.
// Define CONDICIONADOR_SINCRONIZADOR_EN to pass both raw inputs through 2-flop synchronisers first.
module condicionador_jogada #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int CONT_W          = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] chaves,
  input  logic       iniciar,
  output logic [3:0] chaves_estaveis,
  output logic       jogada_valida,
  output logic       jogada_invalida,
  output logic       iniciar_pulso,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO        = 4'd0,
    FILTRANDO     = 4'd1,
    REGISTRA      = 4'd2,
    ESPERA_SOLTAR = 4'd3
  } estado_t;

  localparam logic [CONT_W-1:0] LIMITE = CONT_W'(DEBOUNCE_CICLOS - 1);

  logic [3:0] chaves_s;
  logic       iniciar_s;

`ifdef CONDICIONADOR_SINCRONIZADOR_EN
  logic [3:0] chaves_s1_reg, chaves_s2_reg;
  logic       iniciar_s1_reg, iniciar_s2_reg;

  // The iniciar chain resets high so a button held through reset never looks like a rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      chaves_s1_reg  <= '0;
      chaves_s2_reg  <= '0;
      iniciar_s1_reg <= 1'b1;
      iniciar_s2_reg <= 1'b1;
    end else begin
      chaves_s1_reg  <= chaves;
      chaves_s2_reg  <= chaves_s1_reg;
      iniciar_s1_reg <= iniciar;
      iniciar_s2_reg <= iniciar_s1_reg;
    end
  end

  assign chaves_s  = chaves_s2_reg;
  assign iniciar_s = iniciar_s2_reg;
`else
  assign chaves_s  = chaves;
  assign iniciar_s = iniciar;
`endif

  estado_t           estado_reg, estado_next;
  logic [CONT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]        amostra_reg, amostra_next;
  logic [3:0]        estaveis_reg, estaveis_next;
  logic              iniciar_ant_reg;
  logic              iniciar_pulso_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg        <= OCIOSO;
      cnt_reg           <= '0;
      amostra_reg       <= '0;
      estaveis_reg      <= '0;
      iniciar_ant_reg   <= 1'b1;
      iniciar_pulso_reg <= 1'b0;
    end else begin
      estado_reg        <= estado_next;
      cnt_reg           <= cnt_next;
      amostra_reg       <= amostra_next;
      estaveis_reg      <= estaveis_next;
      iniciar_ant_reg   <= iniciar_s;
      iniciar_pulso_reg <= iniciar_s & ~iniciar_ant_reg;
    end
  end

  always_comb begin
    estado_next     = estado_reg;
    cnt_next        = cnt_reg;
    amostra_next    = amostra_reg;
    estaveis_next   = estaveis_reg;
    jogada_valida   = 1'b0;
    jogada_invalida = 1'b0;
    case (estado_reg)
      OCIOSO: begin
        if (chaves_s != 4'd0) begin
          amostra_next = chaves_s;
          cnt_next     = CONT_W'(1);
          estado_next  = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (chaves_s == 4'd0) begin
          cnt_next    = '0;
          estado_next = OCIOSO;
        end else if (chaves_s != amostra_reg) begin
          amostra_next = chaves_s;
          cnt_next     = CONT_W'(1);
        end else if (cnt_reg == LIMITE) begin
          estaveis_next = amostra_reg;
          estado_next   = REGISTRA;
        end else begin
          cnt_next = cnt_reg + CONT_W'(1);
        end
      end
      REGISTRA: begin
        // Clearing the lowest set bit leaves something only if more than one bit was set.
        jogada_valida   = $onehot(estaveis_reg);
        jogada_invalida = |(estaveis_reg & (estaveis_reg - 4'd1));
        cnt_next        = '0;
        estado_next     = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        if (chaves_s != 4'd0) begin
          cnt_next = '0;
        end else if (cnt_reg == LIMITE) begin
          cnt_next    = '0;
          estado_next = OCIOSO;
        end else begin
          cnt_next = cnt_reg + CONT_W'(1);
        end
      end
      default: begin
        cnt_next    = '0;
        estado_next = OCIOSO;
      end
    endcase
  end

  assign chaves_estaveis = estaveis_reg;
  assign iniciar_pulso   = iniciar_pulso_reg;
  assign db_estado       = estado_reg;

endmodule
